cnn_layer_sched: RTL and testbench
==================================

CNN_LAYER_SCHED -- requirements
Module: cnn_layer_sched

Interface
REQ-001 Parameter DATA_WID, default 16: weight/data word width.
REQ-002 Parameter OCP_NUM, default 8: number of output-channel PE_POOL slices served.
REQ-003 Parameter ADDR_B, default 6: weight-buffer address width; the buffer depth is 2**ADDR_B.
REQ-004 Parameter CNT_B, default 16: pixel counter width.
REQ-005 Parameter DRAIN_CYC, default 4: number of flush cycles after the last MAC.
REQ-006 Port clk, input, 1: the single clock. All logic is rising-edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: single-cycle request to run one layer.
REQ-009 Port cfg_nwt, input, ADDR_B+1: weights per PE, valid range 0..2**ADDR_B; sampled on an accepted start.
REQ-010 Port cfg_npix, input, CNT_B: output pixels to compute; sampled on an accepted start.
REQ-011 Ports wt_valid (input, 1), wt_data (input, DATA_WID), wt_ready (output, 1): weight stream handshake.
REQ-012 Ports act_valid (input, 1) and act_ready (output, 1): activation-vector handshake; the vector data goes straight to the PEs.
REQ-013 Port pe_state, output, 2: PE command. 0=IDLE, 1=LOAD, 2=MAC, 3=FLUSH.
REQ-014 Ports wrb (output, OCP_NUM one-hot), wrb_addr (output, ADDR_B), wrb_data (output, DATA_WID): weight-buffer write port.
REQ-015 Port rdb_addr, output, ADDR_B: weight-buffer read address.
REQ-016 Ports busy (output, 1), done (output, 1, pulse), pix_cnt (output, CNT_B): status.

Function
REQ-017 The FSM states are IDLE, LOAD, COMPUTE, DRAIN and DONE. Every output is registered.
REQ-018 IDLE: start=1 latches cfg_nwt and cfg_npix. Go to DONE if either is 0; otherwise go to LOAD with the PE index and the address counter cleared.
REQ-019 start is ignored in every state other than IDLE.
REQ-020 LOAD:
- wt_ready=1.
- Each wt_valid&wt_ready beat drives, on the next cycle: wrb = one-hot(PE index), wrb_addr = address counter, wrb_data = wt_data, pe_state = LOAD.
- Cycles without a beat drive wrb = 0.
REQ-021 LOAD counters: the address counter increments per beat. At cfg_nwt-1 it wraps to 0 and the PE index increments.
REQ-022 When the beat at PE OCP_NUM-1, address cfg_nwt-1 is accepted, the FSM goes to COMPUTE. wt_ready drops in that same cycle, so there is no extra beat.
REQ-023 COMPUTE:
- act_ready=1.
- Each act_valid beat drives pe_state = MAC and rdb_addr = read counter on the next cycle.
- Cycles without a beat drive pe_state = IDLE and hold rdb_addr.
REQ-024 COMPUTE counters: the read counter wraps at cfg_nwt-1. On each wrap, pix_cnt increments.
REQ-025 The beat that completes pixel cfg_npix-1 moves the FSM to DRAIN, and act_ready drops in that same cycle.
REQ-026 DRAIN: pe_state = FLUSH for exactly DRAIN_CYC cycles, then the FSM goes to DONE.
REQ-027 DONE: done=1 for exactly one cycle, pe_state = IDLE, then the FSM returns to IDLE.
REQ-028 pix_cnt holds its final value until the next accepted start clears it.
REQ-029 busy=1 in LOAD, COMPUTE and DRAIN; busy=0 otherwise.
REQ-030 Each output-affecting handshake has a latency of exactly one cycle, from the accepting edge to the PE command.
REQ-031 Counters saturate at no point. Widths are sized so that the maximum configuration (cfg_nwt = 2**ADDR_B, cfg_npix = 2**CNT_B-1) completes correctly.

Reset
REQ-032 reset=1 at any clock edge, including mid-LOAD or mid-COMPUTE, forces the FSM to IDLE and clears all counters and registers.
REQ-033 The reset value of every output is 0: wt_ready, act_ready, pe_state, wrb, wrb_addr, wrb_data, rdb_addr, busy, done and pix_cnt.
REQ-034 start asserted in the same cycle as reset is ignored.

Structure
REQ-035 The pe_state encodings (PE_IDLE, PE_LOAD, PE_MAC, PE_FLUSH) and the FSM state enum live in the shared CNN package, next to the decoder packet typedefs.
REQ-036 One sub-module, cnn_sched_cnt, is a wrap counter with parameterised width, an enable input, a terminal value input and a wrap output. It is instantiated for the address, PE index, read and pixel counters.
REQ-037 The block is a flat single-FSM design, 120-400 RTL lines.

Verification
REQ-038 OCP_NUM=2, cfg_nwt=3, cfg_npix=2, all valids held at 1 -> 6 LOAD writes with wrb = 01,01,01,10,10,10 and wrb_addr = 0,1,2,0,1,2. Then 6 MAC cycles with rdb_addr = 0,1,2,0,1,2, then 4 FLUSH cycles, then done. pix_cnt ends at 2.
REQ-039 The same configuration with wt_valid toggling 1,0 -> wrb=0 on the gap cycles, the write sequence is identical, and total LOAD time is 12 cycles.
REQ-040 cfg_npix=0 -> DONE on the cycle after start, done pulses once, busy never asserts, and wrb stays at 0.
REQ-041 reset pulsed after the 4th MAC beat -> all outputs are 0 on the next cycle. A new start with cfg_nwt=1, cfg_npix=1 then completes normally.
REQ-042 start re-asserted during COMPUTE -> ignored, and exactly one done pulse occurs.
REQ-043 cfg_nwt=64 (ADDR_B=6) -> wrb_addr reaches 63 and then wraps to 0 with the PE index incremented.

Source files
------------

// File: rtl/cnn_layer_sched_pkg.sv
// rtl/cnn_layer_sched_pkg.sv - shared CNN package: PE commands, scheduler states, decoder packets
package cnn_layer_sched_pkg;

    // Command driven to every PE_POOL slice on pe_state.
    typedef enum logic [1:0] {
        PE_IDLE  = 2'd0,
        PE_LOAD  = 2'd1,
        PE_MAC   = 2'd2,
        PE_FLUSH = 2'd3
    } pe_cmd_e;

    // Layer scheduler FSM.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } sched_state_e;

    // Decoder packet header shared with the layer-descriptor decoder.
    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] length;
    } dec_pkt_hdr_t;

    // Index width for a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_sched_cnt.sv
// rtl/cnn_sched_cnt.sv - wrap counter: counts enabled cycles, returns to 0 after reaching term
//
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   clr         : synchronous clear (start of a new layer)
//   en          : advance the counter this cycle
//   term        : terminal value; the enabled cycle at cnt == term wraps to 0
//   cnt         : current count (registered)
//   wrap        : high in the enabled cycle that wraps (combinational)
module cnn_sched_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == term);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_layer_sched.sv
// rtl/cnn_layer_sched.sv - CNN layer scheduler: weight load, MAC sequencing, drain and done
//
// Ports:
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   start                   : one-cycle layer request, honoured only in IDLE
//   cfg_nwt, cfg_npix       : weights per PE and output pixels, latched on accepted start
//   wt_valid/wt_data/wt_ready : weight stream into the per-PE weight buffers
//   act_valid/act_ready     : activation-vector handshake (data bypasses this block)
//   pe_state                : PE command (IDLE/LOAD/MAC/FLUSH)
//   wrb/wrb_addr/wrb_data   : one-hot weight-buffer write port
//   rdb_addr                : weight-buffer read address
//   busy, done, pix_cnt     : status; done pulses for one cycle per layer
module cnn_layer_sched
    import cnn_layer_sched_pkg::*;
#(
    parameter int DATA_WID  = 16,
    parameter int OCP_NUM   = 8,
    parameter int ADDR_B    = 6,
    parameter int CNT_B     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_B:0]     cfg_nwt,
    input  logic [CNT_B-1:0]    cfg_npix,
    input  logic                wt_valid,
    input  logic [DATA_WID-1:0] wt_data,
    output logic                wt_ready,
    input  logic                act_valid,
    output logic                act_ready,
    output logic [1:0]          pe_state,
    output logic [OCP_NUM-1:0]  wrb,
    output logic [ADDR_B-1:0]   wrb_addr,
    output logic [DATA_WID-1:0] wrb_data,
    output logic [ADDR_B-1:0]   rdb_addr,
    output logic                busy,
    output logic                done,
    output logic [CNT_B-1:0]    pix_cnt
);

    localparam int PE_B = idx_width(OCP_NUM);
    localparam int DR_B = idx_width(DRAIN_CYC + 1);
    localparam logic [PE_B-1:0] PE_TERM = PE_B'(OCP_NUM - 1);

    sched_state_e state_q, state_d;

    logic [ADDR_B:0]    nwt_q;
    logic [CNT_B-1:0]   npix_q;
    logic [ADDR_B-1:0]  nwt_m1;
    logic [CNT_B-1:0]   npix_m1;

    logic               accept, wt_beat, act_beat;
    logic [ADDR_B-1:0]  addr_cnt, rd_cnt;
    logic [PE_B-1:0]    pe_idx;
    logic               addr_wrap, pe_wrap, rd_wrap, pix_last;
    logic               pix_wrap_unused;
    logic [DR_B-1:0]    drain_cnt;
    logic               drain_end;

    // Registered outputs and their next values.
    logic                wt_ready_q, act_ready_q, busy_q, done_q;
    pe_cmd_e             pe_q, pe_d;
    logic [OCP_NUM-1:0]  wrb_q, wrb_d;
    logic [ADDR_B-1:0]   wrb_addr_q, wrb_addr_d, rdb_addr_q, rdb_addr_d;
    logic [DATA_WID-1:0] wrb_data_q, wrb_data_d;

    assign accept   = (state_q == ST_IDLE) && start;
    // Ready flags are only ever high in their own state, so they gate the beats alone.
    assign wt_beat  = wt_valid && wt_ready_q;
    assign act_beat = act_valid && act_ready_q;

    // cfg_nwt may equal the buffer depth; its minus-one always fits ADDR_B bits.
    assign nwt_m1  = ADDR_B'(nwt_q - 1'b1);
    assign npix_m1 = npix_q - 1'b1;

    cnn_sched_cnt #(.W(ADDR_B)) u_addr_cnt (
        .clk(clk), .reset(reset), .clr(accept), .en(wt_beat),
        .term(nwt_m1), .cnt(addr_cnt), .wrap(addr_wrap)
    );

    cnn_sched_cnt #(.W(PE_B)) u_pe_cnt (
        .clk(clk), .reset(reset), .clr(accept), .en(addr_wrap),
        .term(PE_TERM), .cnt(pe_idx), .wrap(pe_wrap)
    );

    cnn_sched_cnt #(.W(ADDR_B)) u_rd_cnt (
        .clk(clk), .reset(reset), .clr(accept), .en(act_beat),
        .term(nwt_m1), .cnt(rd_cnt), .wrap(rd_wrap)
    );

    // The pixel counter never wraps in practice: the FSM leaves COMPUTE as it
    // reaches cfg_npix, which is at most all-ones.
    cnn_sched_cnt #(.W(CNT_B)) u_pix_cnt (
        .clk(clk), .reset(reset), .clr(accept), .en(rd_wrap),
        .term({CNT_B{1'b1}}), .cnt(pix_cnt), .wrap(pix_wrap_unused)
    );

    assign pix_last  = rd_wrap && (pix_cnt == npix_m1);
    // One extra DRAIN cycle shows the final MAC; the following DRAIN_CYC show FLUSH.
    assign drain_end = (drain_cnt == DR_B'(DRAIN_CYC));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pe_d       = PE_IDLE;
        wrb_d      = '0;
        wrb_addr_d = wrb_addr_q;
        wrb_data_d = wrb_data_q;
        rdb_addr_d = rdb_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_nwt == '0 || cfg_npix == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (wt_beat) begin
                    pe_d       = PE_LOAD;
                    wrb_d      = OCP_NUM'(1) << pe_idx;
                    wrb_addr_d = addr_cnt;
                    wrb_data_d = wt_data;
                    if (pe_wrap) begin
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                if (act_beat) begin
                    pe_d       = PE_MAC;
                    rdb_addr_d = rd_cnt;
                    if (pix_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_end) begin
                    state_d = ST_DONE;
                end else begin
                    pe_d = PE_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nwt_q       <= '0;
            npix_q      <= '0;
            drain_cnt   <= '0;
            wt_ready_q  <= 1'b0;
            act_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_q        <= PE_IDLE;
            wrb_q       <= '0;
            wrb_addr_q  <= '0;
            wrb_data_q  <= '0;
            rdb_addr_q  <= '0;
        end else begin
            if (accept) begin
                nwt_q  <= cfg_nwt;
                npix_q <= cfg_npix;
            end
            if (state_q == ST_DRAIN && !drain_end) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
            // Status flags follow the state being entered so they line up with it.
            wt_ready_q  <= (state_d == ST_LOAD);
            act_ready_q <= (state_d == ST_COMPUTE);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_COMPUTE) ||
                           (state_d == ST_DRAIN);
            done_q      <= (state_d == ST_DONE);
            pe_q        <= pe_d;
            wrb_q       <= wrb_d;
            wrb_addr_q  <= wrb_addr_d;
            wrb_data_q  <= wrb_data_d;
            rdb_addr_q  <= rdb_addr_d;
        end
    end

    assign wt_ready  = wt_ready_q;
    assign act_ready = act_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pe_state  = pe_q;
    assign wrb       = wrb_q;
    assign wrb_addr  = wrb_addr_q;
    assign wrb_data  = wrb_data_q;
    assign rdb_addr  = rdb_addr_q;

endmodule

// File: tb/tb_cnn_layer_sched.sv
// tb/tb_cnn_layer_sched.sv - self-checking bench for cnn_layer_sched
module tb_cnn_layer_sched;

    localparam int DW   = 16;
    localparam int OCP  = 2;
    localparam int AB   = 6;
    localparam int CB   = 16;
    localparam int DRN  = 4;

    logic          clk = 1'b0;
    logic          reset, start, wt_valid, act_valid;
    logic [AB:0]   cfg_nwt;
    logic [CB-1:0] cfg_npix;
    logic [DW-1:0] wt_data;
    logic          wt_ready, act_ready, busy, done;
    logic [1:0]    pe_state;
    logic [OCP-1:0] wrb;
    logic [AB-1:0] wrb_addr, rdb_addr;
    logic [DW-1:0] wrb_data;
    logic [CB-1:0] pix_cnt;

    cnn_layer_sched #(
        .DATA_WID(DW), .OCP_NUM(OCP), .ADDR_B(AB), .CNT_B(CB), .DRAIN_CYC(DRN)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_nwt(cfg_nwt), .cfg_npix(cfg_npix),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .act_valid(act_valid), .act_ready(act_ready), .pe_state(pe_state),
        .wrb(wrb), .wrb_addr(wrb_addr), .wrb_data(wrb_data), .rdb_addr(rdb_addr),
        .busy(busy), .done(done), .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OCP-1:0] wrb;
        logic [AB-1:0]  addr;
        logic [DW-1:0]  data;
    } wexp_t;

    typedef struct {
        int nwt;
        int npix;
        int toggle;
        int restart;
        int load;
        int done_at;
        int pix;
        int flush;
    } vec_t;

    wexp_t         wq[$];
    logic [AB-1:0] rq[$];
    wexp_t         we;

    int n_chk = 0, n_pass = 0;
    int load_cyc, act_cyc, flush_cnt, done_cnt, busy_cnt, mac_cnt;
    int k_beat;
    logic done_smp;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] dat(input int k);
        return DW'(32'h3C5A + k * 32'h0107);
    endfunction

    // Scoreboard: writes and MAC read addresses are popped as the DUT emits them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wrb != '0) begin
                if (wq.size() == 0) begin
                    chk("wr_extra", wrb, 0);
                end else begin
                    we = wq.pop_front();
                    chk("wrb", wrb, we.wrb);
                    chk("wrb_addr", wrb_addr, we.addr);
                    chk("wrb_data", wrb_data, we.data);
                    chk("pe_load", pe_state, 1);
                end
            end
            if (pe_state == 2'd2) begin
                mac_cnt++;
                if (rq.size() == 0) chk("mac_extra", pe_state, 0);
                else chk("rdb_addr", rdb_addr, rq.pop_front());
            end
            if (pe_state == 2'd3) flush_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_pe_idle", pe_state, 0);
            end
            if (busy) busy_cnt++;
            if (wt_ready) load_cyc++;
            if (act_ready) act_cyc++;
        end
    end

    task automatic clear_counts();
        load_cyc = 0; act_cyc = 0; flush_cnt = 0; done_cnt = 0; busy_cnt = 0; mac_cnt = 0;
    endtask

    // One clock: sample at negedge, advance weight data after an accepted beat.
    task automatic step();
        bit take;
        @(negedge clk);
        take = wt_valid && wt_ready;
        done_smp = done;
        @(posedge clk);
        #1;
        if (take) begin
            k_beat++;
            wt_data = dat(k_beat);
        end
    endtask

    task automatic expect_layer(input int nwt, input int npix);
        wq.delete();
        rq.delete();
        if (nwt != 0 && npix != 0) begin
            for (int p = 0; p < OCP; p++)
                for (int a = 0; a < nwt; a++)
                    wq.push_back('{wrb: OCP'(1 << p), addr: AB'(a), data: dat(p * nwt + a)});
            for (int x = 0; x < npix; x++)
                for (int a = 0; a < nwt; a++)
                    rq.push_back(AB'(a));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wt_ready"}, wt_ready, 0);
        chk({tag, "_act_ready"}, act_ready, 0);
        chk({tag, "_pe_state"}, pe_state, 0);
        chk({tag, "_wrb"}, wrb, 0);
        chk({tag, "_wrb_addr"}, wrb_addr, 0);
        chk({tag, "_wrb_data"}, wrb_data, 0);
        chk({tag, "_rdb_addr"}, rdb_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pix_cnt"}, pix_cnt, 0);
    endtask

    task automatic run_layer(input vec_t v);
        int  done_at, post, exp_busy;
        bit  restarted;
        expect_layer(v.nwt, v.npix);
        clear_counts();
        mon_en    = 1'b1;
        cfg_nwt   = (AB + 1)'(v.nwt);
        cfg_npix  = CB'(v.npix);
        k_beat    = 0;
        wt_data   = dat(0);
        wt_valid  = 1'b1;
        act_valid = 1'b1;
        start     = 1'b1;
        done_at   = -1;
        post      = 0;
        restarted = 1'b0;
        for (int cyc = 0; cyc < 3000 && post < 4; cyc++) begin
            step();
            if (done_smp && done_at < 0) done_at = cyc;
            start = 1'b0;
            if (v.restart != 0 && act_ready && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (v.toggle != 0) wt_valid = ~wt_valid;
            if (done_at >= 0) post++;
        end
        start     = 1'b0;
        wt_valid  = 1'b0;
        act_valid = 1'b0;
        exp_busy  = (v.nwt == 0 || v.npix == 0) ? 0 : v.load + v.nwt * v.npix + DRN + 1;
        chk("done_at", done_at, v.done_at);
        chk("done_once", done_cnt, 1);
        chk("load_cycles", load_cyc, v.load);
        chk("compute_cycles", act_cyc, v.nwt * v.npix);
        chk("flush_cycles", flush_cnt, v.flush);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("pix_cnt_final", pix_cnt, v.pix);
        chk("writes_left", wq.size(), 0);
        chk("macs_left", rq.size(), 0);
    endtask

    vec_t vt[7];

    initial begin
        //        nwt npix tog rst load done_at pix flush
        vt[0] = '{3,  2,   0,  0,  6,   18,     2,  4};
        vt[1] = '{3,  2,   1,  0,  12,  24,     2,  4};
        vt[2] = '{3,  0,   0,  0,  0,   1,      0,  0};
        vt[3] = '{0,  5,   0,  0,  0,   1,      0,  0};
        vt[4] = '{64, 1,   0,  0,  128, 198,    1,  4};
        vt[5] = '{1,  3,   0,  0,  2,   11,     3,  4};
        vt[6] = '{3,  2,   0,  1,  6,   18,     2,  4};

        reset = 1'b1; start = 1'b0; wt_valid = 1'b0; act_valid = 1'b0;
        cfg_nwt = '0; cfg_npix = '0; wt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_layer(vt[i]);

        // Reset in the middle of COMPUTE, with a start request in the reset cycle.
        expect_layer(3, 2);
        clear_counts();
        cfg_nwt = 7'd3; cfg_npix = 16'd2;
        k_beat = 0; wt_data = dat(0);
        wt_valid = 1'b1; act_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 100 && mac_cnt < 3; c++) step();
        reset = 1'b1;
        start = 1'b1;
        step();
        chk("rst_after_mac4", mac_cnt, 4);
        check_zero("midrst");
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("rst_start_ignored_busy", busy, 0);
        chk("rst_start_ignored_ready", wt_ready, 0);
        wt_valid = 1'b0;
        act_valid = 1'b0;
        rq.delete();
        run_layer('{1, 1, 0, 0, 2, 9, 1, 4});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
